// File: rtl/alu_reservation_station_pkg.sv
// Shared sizing, op constants and the reservation-station entry layout
// for the ALU reservation station and its helpers.
package alu_reservation_station_pkg;

    localparam int RS_SIZE   = 8;
    localparam int ROB_WIDTH = 4;
    localparam int OP_WIDTH  = 6;
    localparam int IDX_WIDTH = $clog2(RS_SIZE);

    localparam logic [OP_WIDTH-1:0] OP_NOP = 6'b111111;

    typedef struct packed {
        logic                 busy;
        logic [OP_WIDTH-1:0]  op;
        logic [31:0]          vj;
        logic                 qj_busy;
        logic [ROB_WIDTH-1:0] qj;
        logic [31:0]          vk;
        logic                 qk_busy;
        logic [ROB_WIDTH-1:0] qk;
        logic [31:0]          imm;
        logic [ROB_WIDTH-1:0] rob_id;
    } rs_entry_t;

    // Returns {hit, value}; the ALU port wins when both ports carry the same tag.
    function automatic logic [32:0] cdb_capture(
        input logic                 alu_valid,
        input logic [ROB_WIDTH-1:0] alu_tag,
        input logic [31:0]          alu_value,
        input logic                 lsb_valid,
        input logic [ROB_WIDTH-1:0] lsb_tag,
        input logic [31:0]          lsb_value,
        input logic [ROB_WIDTH-1:0] tag
    );
        if (alu_valid && (alu_tag == tag)) return {1'b1, alu_value};
        if (lsb_valid && (lsb_tag == tag)) return {1'b1, lsb_value};
        return '0;
    endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB and ALU-drive signals of the ALU reservation station.
// Issue handshake: an entry is written on a rising edge where issue_valid=1 and rs_full=0.
interface alu_reservation_station_if;
    import alu_reservation_station_pkg::*;

    logic                 issue_valid;
    logic [OP_WIDTH-1:0]  issue_op;
    logic [31:0]          issue_vj;
    logic [31:0]          issue_vk;
    logic [31:0]          issue_imm;
    logic                 issue_qj_busy;
    logic                 issue_qk_busy;
    logic [ROB_WIDTH-1:0] issue_qj;
    logic [ROB_WIDTH-1:0] issue_qk;
    logic [ROB_WIDTH-1:0] issue_rob_id;

    logic                 cdb_alu_valid;
    logic                 cdb_lsb_valid;
    logic [ROB_WIDTH-1:0] cdb_alu_tag;
    logic [ROB_WIDTH-1:0] cdb_lsb_tag;
    logic [31:0]          cdb_alu_value;
    logic [31:0]          cdb_lsb_value;

    logic                 rs_full;
    logic                 alu_waiting;
    logic [OP_WIDTH-1:0]  alu_op;
    logic [31:0]          alu_vj;
    logic [31:0]          alu_vk;
    logic [31:0]          alu_imm;
    logic [ROB_WIDTH-1:0] alu_issue_rob_id;
    logic [ROB_WIDTH-1:0] alu_result_rob_id;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_imm,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob_id,
               cdb_alu_valid, cdb_lsb_valid, cdb_alu_tag, cdb_lsb_tag,
               cdb_alu_value, cdb_lsb_value,
        input  rs_full, alu_waiting, alu_op, alu_vj, alu_vk, alu_imm,
               alu_issue_rob_id, alu_result_rob_id
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_imm,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob_id,
               cdb_alu_valid, cdb_lsb_valid, cdb_alu_tag, cdb_lsb_tag,
               cdb_alu_value, cdb_lsb_value,
        output rs_full, alu_waiting, alu_op, alu_vj, alu_vk, alu_imm,
               alu_issue_rob_id, alu_result_rob_id
    );

endinterface

// File: rtl/alu_reservation_station_priority_encoder.sv
// Lowest-index search over a request vector: found flag plus index.
module rs_priority_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station between dispatch and the ALU: captures CDB operands
// and hands the lowest-index ready entry to the ALU each cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic RoB_clear,
    alu_reservation_station_if.slave bus
);

    localparam rs_entry_t ENTRY_EMPTY = '{op: OP_NOP, default: '0};

    rs_entry_t            entries [RS_SIZE];
    logic [RS_SIZE-1:0]   busy_vec;
    logic [RS_SIZE-1:0]   ready_vec;
    logic [32:0]          wake_j [RS_SIZE];
    logic [32:0]          wake_k [RS_SIZE];
    logic [32:0]          iss_j;
    logic [32:0]          iss_k;
    rs_entry_t            issue_entry;
    logic                 free_found;
    logic [IDX_WIDTH-1:0] free_idx;
    logic                 sel_found;
    logic [IDX_WIDTH-1:0] sel_idx;
    logic                 issue_accept;

    logic                 alu_waiting_q;
    logic [OP_WIDTH-1:0]  alu_op_q;
    logic [31:0]          alu_vj_q;
    logic [31:0]          alu_vk_q;
    logic [31:0]          alu_imm_q;
    logic [ROB_WIDTH-1:0] alu_issue_rob_id_q;
    logic [ROB_WIDTH-1:0] alu_result_rob_id_q;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entries[i].busy;
            ready_vec[i] = entries[i].busy && !entries[i].qj_busy && !entries[i].qk_busy;
            wake_j[i] = cdb_capture(bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_value,
                                    bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_value,
                                    entries[i].qj);
            wake_k[i] = cdb_capture(bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_value,
                                    bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_value,
                                    entries[i].qk);
        end
    end

    rs_priority_encoder #(.N(RS_SIZE), .W(IDX_WIDTH)) u_free_search (
        .req   (~busy_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_priority_encoder #(.N(RS_SIZE), .W(IDX_WIDTH)) u_ready_select (
        .req   (ready_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Operands broadcast in the issue cycle are folded in before the write.
    always_comb begin
        iss_j = cdb_capture(bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_value,
                            bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_value,
                            bus.issue_qj);
        iss_k = cdb_capture(bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_value,
                            bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_value,
                            bus.issue_qk);
        issue_entry         = '0;
        issue_entry.busy    = 1'b1;
        issue_entry.op      = bus.issue_op;
        issue_entry.imm     = bus.issue_imm;
        issue_entry.rob_id  = bus.issue_rob_id;
        issue_entry.qj      = bus.issue_qj;
        issue_entry.qk      = bus.issue_qk;
        issue_entry.qj_busy = bus.issue_qj_busy && !iss_j[32];
        issue_entry.qk_busy = bus.issue_qk_busy && !iss_k[32];
        issue_entry.vj      = (bus.issue_qj_busy && iss_j[32]) ? iss_j[31:0] : bus.issue_vj;
        issue_entry.vk      = (bus.issue_qk_busy && iss_k[32]) ? iss_k[31:0] : bus.issue_vk;
    end

    assign issue_accept = bus.issue_valid && free_found;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) entries[i] <= ENTRY_EMPTY;
            alu_waiting_q       <= 1'b0;
            alu_op_q            <= '0;
            alu_vj_q            <= '0;
            alu_vk_q            <= '0;
            alu_imm_q           <= '0;
            alu_issue_rob_id_q  <= '0;
            alu_result_rob_id_q <= '0;
        end else if (rdy_in) begin
            if (RoB_clear) begin
                for (int i = 0; i < RS_SIZE; i++) entries[i].busy <= 1'b0;
                alu_waiting_q       <= 1'b0;
                alu_op_q            <= '0;
                alu_vj_q            <= '0;
                alu_vk_q            <= '0;
                alu_imm_q           <= '0;
                alu_issue_rob_id_q  <= '0;
                alu_result_rob_id_q <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (entries[i].busy) begin
                        if (entries[i].qj_busy && wake_j[i][32]) begin
                            entries[i].vj      <= wake_j[i][31:0];
                            entries[i].qj_busy <= 1'b0;
                        end
                        if (entries[i].qk_busy && wake_k[i][32]) begin
                            entries[i].vk      <= wake_k[i][31:0];
                            entries[i].qk_busy <= 1'b0;
                        end
                    end
                end
                if (sel_found) begin
                    entries[sel_idx].busy <= 1'b0;
                    alu_waiting_q         <= 1'b1;
                    alu_op_q              <= entries[sel_idx].op;
                    alu_vj_q              <= entries[sel_idx].vj;
                    alu_vk_q              <= entries[sel_idx].vk;
                    alu_imm_q             <= entries[sel_idx].imm;
                    alu_issue_rob_id_q    <= entries[sel_idx].rob_id;
                end else begin
                    alu_waiting_q      <= 1'b0;
                    alu_op_q           <= '0;
                    alu_vj_q           <= '0;
                    alu_vk_q           <= '0;
                    alu_imm_q          <= '0;
                    alu_issue_rob_id_q <= '0;
                end
                // free_idx points at an entry that was idle, never the selected one.
                if (issue_accept) entries[free_idx] <= issue_entry;
                alu_result_rob_id_q <= alu_issue_rob_id_q;
            end
        end
    end

    assign bus.rs_full           = &busy_vec;
    assign bus.alu_waiting       = alu_waiting_q;
    assign bus.alu_op            = alu_op_q;
    assign bus.alu_vj            = alu_vj_q;
    assign bus.alu_vk            = alu_vk_q;
    assign bus.alu_imm           = alu_imm_q;
    assign bus.alu_issue_rob_id  = alu_issue_rob_id_q;
    assign bus.alu_result_rob_id = alu_result_rob_id_q;

endmodule
